ksa_seq_ctrl: RTL

Sequencer and arbiter for a single shared 16-bit Kogge-Stone adder slice (with carry-in). Performs wide add/subtract (16*SLICES bits) by stepping the operands through the adder one 16-bit slice per clock and registering the carry between slices. Two requesters (Wishbone-side port 0, logic-analyzer-side port 1) share the adder under round-robin arbitration. Results return on a valid/ready response channel tagged with the requester id.

---
 rtl/ksa_seq_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ksa_seq_ctrl.sv
// Sequencer/arbiter that streams wide add/sub operations through one shared
// 16-bit adder slice, one slice per clock, with round-robin arbitration between two requesters.
module ksa_seq_ctrl #(
    parameter int SLICES = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [16*SLICES-1:0]   req0_a,
    input  logic [16*SLICES-1:0]   req0_b,
    input  logic                   req0_sub,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [16*SLICES-1:0]   req1_a,
    input  logic [16*SLICES-1:0]   req1_b,
    input  logic                   req1_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [16*SLICES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic                   busy,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    output logic                   add_cin,
    input  logic [15:0]            add_sum,
    input  logic                   add_cout
);

    localparam int W  = 16 * SLICES;
    localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic            rsp_ovf_q, rsp_ovf_d;

    logic            grant;
    logic            sel_sub;
    logic [W-1:0]    sel_b;
    logic            last_slice;

    // With both requesters valid the round-robin pointer decides; otherwise the valid one wins.
    assign grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign sel_sub    = grant ? req1_sub : req0_sub;
    assign sel_b      = grant ? req1_b : req0_b;
    assign last_slice = (cnt_q == CW'(SLICES - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    a_d        = grant ? req1_a : req0_a;
                    b_d        = sel_sub ? ~sel_b : sel_b;
                    carry_d    = sel_sub;
                    cnt_d      = '0;
                    id_d       = grant;
                    rr_d       = ~grant;
                    state_d    = RUN;
                end
            end
            RUN: begin
                add_a                 = a_q[16*cnt_q +: 16];
                add_b                 = b_q[16*cnt_q +: 16];
                add_cin               = carry_q;
                res_d[16*cnt_q +: 16] = add_sum;
                carry_d               = add_cout;
                cnt_d                 = cnt_q + 1'b1;
                if (last_slice) begin
                    cnt_d       = '0;
                    rsp_sum_d   = res_d;
                    rsp_cout_d  = add_cout;
                    rsp_ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[15] != a_q[W-1]);
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    // NOTE: operand and partial-result registers carry no reset; they are always written before being read.
    always_ff @(posedge wb_clk_i) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != IDLE);

endmodule
